// File: rtl/exec_pkg.sv
// Shared execute-stage types and constants for the vector fork path.
// Chunk geometry helpers are used by fork_vector and fork_chunk_counter.
package exec_pkg;

    localparam logic [1:0] OP_SCALAR  = 2'b00;
    localparam logic [1:0] OP_VEC_VEC = 2'b01;
    localparam logic [1:0] OP_VEC_SCA = 2'b10;

    localparam int LANES_DEF = 4;

    function automatic int calc_nchunk(input int v, input int lanes);
        return (v + lanes - 1) / lanes;
    endfunction

    function automatic int calc_last(input int v, input int lanes);
        return lanes * (calc_nchunk(v, lanes) - 1);
    endfunction

    function automatic int chunk_idx_w(input int v, input int lanes);
        return (calc_nchunk(v, lanes) > 1) ? $clog2(calc_nchunk(v, lanes)) : 1;
    endfunction

    function automatic logic is_vec_op(input logic [1:0] op);
        return (op == OP_VEC_VEC) || (op == OP_VEC_SCA);
    endfunction

endpackage

// File: rtl/fork_chunk_counter.sv
// Chunk base-index register for the vector fork: steps by LANES,
// wraps after the last chunk and flags completion on ready_o.
module fork_chunk_counter
    import exec_pkg::*;
#(
    parameter int V     = 20,
    parameter int LANES = LANES_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        vec_op_i,
    output logic [31:0] counter_o,
    output logic        ready_o
);

    localparam logic [31:0] LAST = 32'(calc_last(V, LANES));
    localparam logic [31:0] STEP = 32'(LANES);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic        at_last;

    assign at_last = (cnt_q == LAST);

    always_comb begin
        cnt_d = '0;
        if (vec_op_i && !at_last) begin
            cnt_d = cnt_q + STEP;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign counter_o = cnt_q;
    assign ready_o   = !vec_op_i || at_last;

endmodule

// File: rtl/fork_vector.sv
// Execute-stage vector splitter feeding LANES scalar ALUs one chunk per cycle.
// Define FORK_CHUNK_IDX_EN to add the chunk_idx_o output.
module fork_vector
    import exec_pkg::*;
#(
    parameter int N     = 32,
    parameter int V     = 20,
    parameter int LANES = LANES_DEF
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [1:0]                  OpType,
    input  logic [V-1:0][N-1:0]         RD1_VEC_i,
    input  logic [V-1:0][N-1:0]         RD2_VEC_i,
    input  logic [N-1:0]                Scalar_i,
    output logic [LANES-1:0][N-1:0]     Vec_A_o,
    output logic [LANES-1:0][N-1:0]     Vec_B_o,
    output logic [31:0]                 counter,
`ifdef FORK_CHUNK_IDX_EN
    output logic [chunk_idx_w(V, LANES)-1:0] chunk_idx_o,
`endif
    output logic                        ready_o
);

    logic                    vec_op;
    logic [LANES-1:0][31:0]  lane_e;

    assign vec_op = is_vec_op(OpType);

    fork_chunk_counter #(
        .V     (V),
        .LANES (LANES)
    ) u_cnt (
        .clk_i     (CLK),
        .rst_i     (RST),
        .vec_op_i  (vec_op),
        .counter_o (counter),
        .ready_o   (ready_o)
    );

`ifdef FORK_CHUNK_IDX_EN
    assign chunk_idx_o = chunk_idx_w(V, LANES)'(counter / 32'(LANES));
`endif

    for (genvar k = 0; k < LANES; k++) begin : g_lane_e
        assign lane_e[k] = counter + 32'(k);
    end

    // Match against each element so lanes past V-1 read zero, never out of range.
    always_comb begin
        Vec_A_o = '0;
        Vec_B_o = '0;
        for (int k = 0; k < LANES; k++) begin
            for (int j = 0; j < V; j++) begin
                if (vec_op && (lane_e[k] == 32'(j))) begin
                    Vec_A_o[k] = RD1_VEC_i[j];
                    if (OpType == OP_VEC_VEC) begin
                        Vec_B_o[k] = RD2_VEC_i[j];
                    end else begin
                        Vec_B_o[k] = Scalar_i;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fork_vector.sv
// Scoreboard bench for fork_vector at V=20, V=18 and V=3 sharing one stimulus.
// A chunk-number reference model predicts each cycle's lane outputs.
module tb_fork_vector;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic [1:0]          OpType = 2'b00;
    logic [19:0][31:0]   rd1;
    logic [19:0][31:0]   rd2;
    logic [31:0]         sca;

    logic [3:0][31:0] a20, b20, a18, b18, a3, b3;
    logic [31:0]      c20, c18, c3;
    logic             r20, r18, r3;
`ifdef FORK_CHUNK_IDX_EN
    logic [2:0]       ci20, ci18;
    logic [0:0]       ci3;
`endif

    int pass_cnt = 0;
    int total = 0;

    always #5 CLK = ~CLK;

    fork_vector #(.N(32), .V(20), .LANES(4)) dut20 (
        .CLK(CLK), .RST(RST), .OpType(OpType),
        .RD1_VEC_i(rd1), .RD2_VEC_i(rd2), .Scalar_i(sca),
        .Vec_A_o(a20), .Vec_B_o(b20), .counter(c20),
`ifdef FORK_CHUNK_IDX_EN
        .chunk_idx_o(ci20),
`endif
        .ready_o(r20)
    );

    fork_vector #(.N(32), .V(18), .LANES(4)) dut18 (
        .CLK(CLK), .RST(RST), .OpType(OpType),
        .RD1_VEC_i(rd1[17:0]), .RD2_VEC_i(rd2[17:0]), .Scalar_i(sca),
        .Vec_A_o(a18), .Vec_B_o(b18), .counter(c18),
`ifdef FORK_CHUNK_IDX_EN
        .chunk_idx_o(ci18),
`endif
        .ready_o(r18)
    );

    fork_vector #(.N(32), .V(3), .LANES(4)) dut3 (
        .CLK(CLK), .RST(RST), .OpType(OpType),
        .RD1_VEC_i(rd1[2:0]), .RD2_VEC_i(rd2[2:0]), .Scalar_i(sca),
        .Vec_A_o(a3), .Vec_B_o(b3), .counter(c3),
`ifdef FORK_CHUNK_IDX_EN
        .chunk_idx_o(ci3),
`endif
        .ready_o(r3)
    );

    typedef struct {
        logic [31:0]      cnt;
        logic [3:0][31:0] a;
        logic [3:0][31:0] b;
        logic             rdy;
        int               ch;
    } exp1_t;

    typedef struct {
        exp1_t x20;
        exp1_t x18;
        exp1_t x3;
    } exp_t;

    exp_t q[$];
    int   ch20 = 0, ch18 = 0, ch3 = 0;

    function automatic int nchunk(input int v);
        return (v + 3) / 4;
    endfunction

    function automatic int next_chunk(input int v, input int ch);
        if (RST) return 0;
        if (OpType == 2'b01 || OpType == 2'b10) return (ch + 1) % nchunk(v);
        return 0;
    endfunction

    function automatic exp1_t model(input int v, input int ch);
        exp1_t r;
        int    e;
        logic  vec;
        vec   = (OpType == 2'b01) || (OpType == 2'b10);
        r.ch  = ch;
        r.cnt = 32'(ch * 4);
        r.a   = '0;
        r.b   = '0;
        for (int k = 0; k < 4; k++) begin
            e = ch * 4 + k;
            if (vec && e < v) begin
                r.a[k] = rd1[e];
                r.b[k] = (OpType == 2'b01) ? rd2[e] : sca;
            end
        end
        r.rdy = !vec || (ch == nchunk(v) - 1);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    endtask

    task automatic cmp1(input string tag, input exp1_t e, input logic [31:0] c,
                        input logic [127:0] a, input logic [127:0] b,
                        input logic r);
        chk({tag, "_counter"}, 128'(c), 128'(e.cnt));
        chk({tag, "_vec_a"}, a, e.a);
        chk({tag, "_vec_b"}, b, e.b);
        chk({tag, "_ready"}, 128'(r), 128'(e.rdy));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp1("v20", e.x20, c20, a20, b20, r20);
                cmp1("v18", e.x18, c18, a18, b18, r18);
                cmp1("v3", e.x3, c3, a3, b3, r3);
`ifdef FORK_CHUNK_IDX_EN
                chk("v20_chunk_idx", 128'(ci20), 128'(e.x20.ch));
                chk("v18_chunk_idx", 128'(ci18), 128'(e.x18.ch));
                chk("v3_chunk_idx", 128'(ci3), 128'(e.x3.ch));
`endif
            end
        end
    end

    task automatic directed_data();
        for (int i = 0; i < 20; i++) begin
            rd1[i] = 32'(i);
            rd2[i] = 32'(2 * i);
        end
        sca = 32'd5;
    endtask

    task automatic random_data();
        for (int i = 0; i < 20; i++) begin
            rd1[i] = $urandom;
            rd2[i] = $urandom;
        end
        sca = $urandom;
    endtask

    task automatic cyc(input logic [1:0] op, input logic rst_n, input bit rnd);
        exp_t e;
        @(posedge CLK);
        #1;
        ch20 = next_chunk(20, ch20);
        ch18 = next_chunk(18, ch18);
        ch3  = next_chunk(3, ch3);
        OpType = op;
        RST    = rst_n;
        if (RST) begin
            ch20 = 0;
            ch18 = 0;
            ch3  = 0;
        end
        if (rnd) random_data();
        e.x20 = model(20, ch20);
        e.x18 = model(18, ch18);
        e.x3  = model(3, ch3);
        q.push_back(e);
    endtask

    task automatic async_rst();
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst_counter", 128'(c20), 128'(0));
        chk("async_rst_ready", 128'(r20), 128'(0));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        logic [1:0] op;
        directed_data();
        for (int i = 0; i < 10; i++) cyc(2'b10, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc(2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(2'b01, 1'b0, 1'b0);
        async_rst();
        cyc(2'b01, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cyc(2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc(2'b11, 1'b0, 1'b0);
        op = 2'b01;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 2) op = 2'($urandom_range(0, 3));
            cyc(op, ($urandom_range(0, 49) == 0), 1'b1);
        end
        @(negedge CLK);
        #1;
        chk("scoreboard_drained", 128'(q.size()), 128'(0));
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/fork_vector.md
Name: fork_vector

Overview:
- Execute-stage vector splitter. It feeds V-element vector operands to a bank of LANES scalar ALUs, one LANES-wide chunk per clock.
- It drives a chunk base index (counter) so a downstream join block can place each chunk's results.
- It raises ready_o when the final chunk is presented, which lets the EX/MEM pipe register advance.
- Scalar-only ops bypass it: ready_o stays 1.

Parameters:
- N, 32, element width in bits.
- V, 20, elements per vector; must satisfy V >= 1.
- LANES, 4, parallel ALU lanes (chunk size).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- OpType  in  2  operation class: 00 scalar, 01 vector-vector, 10 vector-scalar, 11 reserved (treated as scalar).
- RD1_VEC_i  in  V x N  vector operand A, element i at index i.
- RD2_VEC_i  in  V x N  vector operand B.
- Scalar_i  in  N  scalar operand, broadcast for vector-scalar ops.
- Vec_A_o  out  LANES x N  lane A operands.
- Vec_B_o  out  LANES x N  lane B operands.
- counter  out  32 (integer)  element index of lane 0 in the current chunk.
- ready_o  out  1  operation complete this cycle.

Behaviour:
- Clocking and reset: single clock domain. Asynchronous, active-high reset on RST.
- State: only the counter register (32-bit). All other outputs are combinational from counter, OpType and the inputs, so there is zero latency to the ALUs.
- Reset: counter = 0 immediately on RST, including mid-operation. The in-flight operation is abandoned and restarts from chunk 0 after release.
- Derived constants: NCHUNK = ceil(V/LANES); LAST = LANES*(NCHUNK-1).
- Vector op (OpType 01 or 10), each rising edge:
  - if counter == LAST, counter <= 0;
  - otherwise counter <= counter + LANES.
- Scalar/reserved op: counter <= 0 every edge. A vector op that changes to scalar mid-way therefore clears the counter on the next edge.
- Lane k mapping, with e = counter + k:
  - Vec_A_o[k] = RD1_VEC_i[e] if e < V, else 0.
  - OpType 01: Vec_B_o[k] = RD2_VEC_i[e] if e < V, else 0.
  - OpType 10: Vec_B_o[k] = Scalar_i for e < V, else 0.
  - OpType 00/11: Vec_A_o = Vec_B_o = 0.
- ready_o:
  - 1 when OpType is 00/11;
  - 1 when OpType is 01/10 and counter == LAST;
  - 0 otherwise.
- A vector op therefore takes exactly NCHUNK cycles, with ready_o high in the last one.
- V <= LANES: LAST = 0, so ready_o is 1 every cycle and the counter stays at 0.
- Back-to-back ops: the edge that ends one op (counter 0) starts the next op's chunk 0. There is no idle bubble.
- Inputs must be held stable by the upstream pipe for the op's duration; the block does not latch operands.
- Index arithmetic is unsigned; out-of-range lanes never index past V-1.

Optional Feature:
- Macro: FORK_CHUNK_IDX_EN.
- When defined, adds output chunk_idx_o with width max(1, $clog2(NCHUNK)), equal to counter / LANES. It resets to 0 and wraps with counter.
- When undefined, the port does not exist and no extra logic is generated.
- Other behaviour is identical in both cases.

Decomposition:
- Shared package exec_pkg holds:
  - OpType encodings: OP_SCALAR=2'b00, OP_VEC_VEC=2'b01, OP_VEC_SCA=2'b10;
  - the default LANES constant;
  - a function computing NCHUNK/LAST from V and LANES.
- One sub-module is natural: fork_chunk_counter. It owns the counter register, wrap logic and ready_o generation.
- The lane mux stays in fork_vector.

Test Plan:
- V=20, N=32, RD1[i]=i, RD2[i]=2i, Scalar_i=5, OpType=10 after reset:
  - cycle 0: counter=0, Vec_A={0,1,2,3}, Vec_B={5,5,5,5}, ready_o=0;
  - after 4 edges: counter=16, Vec_A={16,17,18,19}, ready_o=1;
  - next edge: counter=0.
- OpType=01, same data:
  - counter 0: Vec_B={0,2,4,6};
  - counter 8: Vec_A={8..11}, Vec_B={16,18,20,22}, ready_o=0;
  - counter 16: Vec_B={32,34,36,38}, ready_o=1.
- OpType=00: ready_o=1 every cycle, counter=0, Vec_A/Vec_B all 0. Switching 01→00 at counter=8 gives counter=0 on the next edge.
- Assert RST asynchronously while counter=12 (OpType=01): counter=0 before the next edge and ready_o=0. After release, chunk sequence 0,4,8,12,16 resumes.
- Parameter V=18: chunks 0,4,8,12,16; at counter=16, Vec_A={16,17,0,0}, ready_o=1. V=3: ready_o=1 each cycle, Vec_A={0,1,2,0}.
- Back-to-back: two consecutive OpType=10 ops of 5 chunks each give ready_o high at cycles 4 and 9 and low elsewhere.
